// File: rtl/gf_poly_eval_pkg.sv
// Shared GF(2^8) constants, FSM state encoding and the bit-serial field multiply
// used by the evaluator datapath.
package gf_poly_eval_pkg;

    localparam int GF_W = 8;
    // Low byte of the field polynomial x^8+x^4+x^3+x^2+1 (0x11D).
    localparam logic [GF_W-1:0] GF_POLY = 8'h1D;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FETCH,
        S_MUL,
        S_WAIT,
        S_ACC,
        S_DONE
    } state_t;

    function automatic logic [GF_W-1:0] gf_mult(input logic [GF_W-1:0] a,
                                                input logic [GF_W-1:0] b);
        logic [GF_W-1:0] p;
        logic [GF_W-1:0] t;
        p = '0;
        t = a;
        for (int i = 0; i < GF_W; i++) begin
            if (b[i]) p = p ^ t;
            t = t[GF_W-1] ? ((t << 1) ^ GF_POLY) : (t << 1);
        end
        return p;
    endfunction

endpackage

// File: rtl/gf_mul.sv
// GF(2^8) multiplier with optional input and output register stages.
// With REG_IN=REG_OUT=1, done and mul_out appear two cycles after start.
module gf_mul
    import gf_poly_eval_pkg::*;
#(
    parameter bit REG_IN  = 1'b1,
    parameter bit REG_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            start,
    input  logic [GF_W-1:0] in_1,
    input  logic [GF_W-1:0] in_2,
    output logic            done,
    output logic [GF_W-1:0] mul_out
);

    logic [GF_W-1:0] a_q;
    logic [GF_W-1:0] b_q;
    logic [GF_W-1:0] prod;
    logic            v_q;

    // NOTE: these datapath flops deliberately have no reset; the consumer only
    // trusts done while it is actually waiting for a product.
    generate
        if (REG_IN) begin : g_reg_in
            always_ff @(posedge clk) begin
                v_q <= start;
                if (start) begin
                    a_q <= in_1;
                    b_q <= in_2;
                end
            end
        end else begin : g_comb_in
            assign v_q = start;
            assign a_q = in_1;
            assign b_q = in_2;
        end
    endgenerate

    assign prod = gf_mult(a_q, b_q);

    generate
        if (REG_OUT) begin : g_reg_out
            always_ff @(posedge clk) begin
                done    <= v_q;
                mul_out <= prod;
            end
        end else begin : g_comb_out
            assign done    = v_q;
            assign mul_out = prod;
        end
    endgenerate

endmodule

// File: rtl/gf_poly_eval.sv
// Horner-rule evaluator of p(r) = sum c_i r^i over GF(2^8); coefficients come
// from a 1-cycle-latency RAM, highest index first, products from gf_mul.
module gf_poly_eval
    import gf_poly_eval_pkg::*;
#(
    parameter int N_COEFF = 8,
    parameter int ADDR_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [GF_W-1:0]   eval_point,
    output logic              coeff_rd,
    output logic [ADDR_W-1:0] coeff_addr,
    input  logic [GF_W-1:0]   coeff_data,
    output logic              busy,
    output logic              done,
    output logic [GF_W-1:0]   result
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N_COEFF - 1);
    localparam logic [ADDR_W-1:0] IDX_FIRST = ADDR_W'((N_COEFF > 1) ? N_COEFF - 2 : 0);

    state_t            state;
    state_t            next_state;
    logic [GF_W-1:0]   r_reg;
    logic [GF_W-1:0]   acc;
    logic [GF_W-1:0]   acc_next;
    logic [GF_W-1:0]   coeff_lat;
    logic [ADDR_W-1:0] idx;
    logic              mul_start;
    logic              mul_done;
    logic [GF_W-1:0]   mul_out;

    gf_mul #(
        .REG_IN  (1'b1),
        .REG_OUT (1'b1)
    ) u_gf_mul (
        .clk     (clk),
        .start   (mul_start),
        .in_1    (acc),
        .in_2    (r_reg),
        .done    (mul_done),
        .mul_out (mul_out)
    );

    // NOTE: sequential state always uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    always_comb begin
        next_state = state;
        mul_start  = 1'b0;
        acc_next   = acc;
        case (state)
            S_IDLE:  if (start) next_state = S_LOAD;
            S_LOAD:  next_state = S_FETCH;
            S_FETCH: begin
                acc_next   = coeff_data;
                next_state = (N_COEFF == 1) ? S_DONE : S_MUL;
            end
            S_MUL: begin
                mul_start  = 1'b1;
                next_state = S_WAIT;
            end
            S_WAIT:  next_state = S_ACC;
            S_ACC: begin
                if (mul_done) begin
                    acc_next   = mul_out ^ coeff_lat;
                    next_state = (idx == '0) ? S_DONE : S_MUL;
                end
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    assign done = (state == S_DONE);

    // Read strobe and address are registered one step ahead, so the address
    // simply holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg      <= '0;
            acc        <= '0;
            coeff_lat  <= '0;
            idx        <= '0;
            busy       <= 1'b0;
            result     <= '0;
            coeff_rd   <= 1'b0;
            coeff_addr <= '0;
        end else begin
            acc      <= acc_next;
            busy     <= (next_state != S_IDLE);
            coeff_rd <= (next_state == S_LOAD) || (next_state == S_MUL);
            if (state == S_IDLE && start) r_reg <= eval_point;
            if (state == S_WAIT) coeff_lat <= coeff_data;
            if (next_state == S_DONE) result <= acc_next;
            if (state == S_FETCH) idx <= IDX_FIRST;
            else if (state == S_ACC && next_state == S_MUL) idx <= idx - 1'b1;
            if (next_state == S_LOAD) coeff_addr <= ADDR_LAST;
            else if (next_state == S_MUL)
                coeff_addr <= (state == S_FETCH) ? IDX_FIRST : idx - 1'b1;
        end
    end

endmodule

// File: tb/tb_gf_poly_eval.sv
// Directed bench: four evaluator instances (N_COEFF = 1, 2, 3, 8), each with its
// own coefficient RAM model, checked against hand-computed GF(2^8) values.
module tb_gf_poly_eval;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]      eval_point;
    logic [3:0]      start_v;
    logic [3:0]      rd_v;
    logic [3:0]      busy_v;
    logic [3:0]      done_v;
    logic [3:0][2:0] addr_v;
    logic [3:0][7:0] data_v;
    logic [3:0][7:0] res_v;
    logic [7:0]      mem [4][8];

    int n_checks = 0;
    int n_fail   = 0;
    int addr_q[$];

    gf_poly_eval #(.N_COEFF(1), .ADDR_W(3)) u_n1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .eval_point(eval_point),
        .coeff_rd(rd_v[0]), .coeff_addr(addr_v[0]), .coeff_data(data_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .result(res_v[0]));

    gf_poly_eval #(.N_COEFF(2), .ADDR_W(3)) u_n2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .eval_point(eval_point),
        .coeff_rd(rd_v[1]), .coeff_addr(addr_v[1]), .coeff_data(data_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .result(res_v[1]));

    gf_poly_eval #(.N_COEFF(3), .ADDR_W(3)) u_n3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .eval_point(eval_point),
        .coeff_rd(rd_v[2]), .coeff_addr(addr_v[2]), .coeff_data(data_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .result(res_v[2]));

    gf_poly_eval #(.N_COEFF(8), .ADDR_W(3)) u_n8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]), .eval_point(eval_point),
        .coeff_rd(rd_v[3]), .coeff_addr(addr_v[3]), .coeff_data(data_v[3]),
        .busy(busy_v[3]), .done(done_v[3]), .result(res_v[3]));

    // One-cycle-latency coefficient RAMs.
    always @(posedge clk) begin
        for (int d = 0; d < 4; d++)
            if (rd_v[d]) data_v[d] <= mem[d][addr_v[d]];
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Start one evaluation on instance d and watch it for a fixed 60-cycle window.
    task automatic run(input int d, input logic [7:0] r, input int mid_at,
                       input bit start_in_done, output logic [7:0] res,
                       output int lat, output int ndone, output int busy_bad);
        lat = -1;
        ndone = 0;
        busy_bad = 0;
        res = 8'h00;
        addr_q.delete();
        @(posedge clk);
        #1;
        eval_point = r;
        start_v[d] = 1'b1;
        @(posedge clk);
        #1;
        start_v[d] = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (rd_v[d]) addr_q.push_back(int'(addr_v[d]));
            @(posedge clk);
            #1;
            start_v[d] = 1'b0;
            if (done_v[d]) begin
                ndone++;
                if (lat < 0) begin
                    lat = c;
                    res = res_v[d];
                end
                if (start_in_done) start_v[d] = 1'b1;
            end else if (lat < 0 && !busy_v[d]) begin
                busy_bad++;
            end
            if (c == mid_at) start_v[d] = 1'b1;
        end
    endtask

    logic [7:0] res;
    int lat, ndone, busy_bad;

    initial begin
        start_v = '0;
        eval_point = 8'h00;
        for (int d = 0; d < 4; d++)
            for (int a = 0; a < 8; a++)
                mem[d][a] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            check($sformatf("reset_busy_%0d", d), busy_v[d], 0);
            check($sformatf("reset_done_%0d", d), done_v[d], 0);
            check($sformatf("reset_result_%0d", d), res_v[d], 0);
            check($sformatf("reset_rd_%0d", d), rd_v[d], 0);
            check($sformatf("reset_addr_%0d", d), addr_v[d], 0);
        end
        rst_n = 1'b1;

        // N=1: result is c0 regardless of r.
        mem[0][0] = 8'h5A;
        run(0, 8'h37, -1, 1'b0, res, lat, ndone, busy_bad);
        check("n1_result", res, 8'h5A);
        check("n1_latency", lat, 2);
        check("n1_ndone", ndone, 1);

        // N=2: 1*2 ^ 1 = 3.
        mem[1][0] = 8'h01; mem[1][1] = 8'h01;
        run(1, 8'h02, -1, 1'b0, res, lat, ndone, busy_bad);
        check("n2_basic_result", res, 8'h03);
        check("n2_basic_latency", lat, 5);
        check("n2_basic_busy", busy_bad, 0);
        check("n2_basic_ndone", ndone, 1);

        // N=2: 0x80*2 reduces by 0x11D.
        mem[1][0] = 8'h00; mem[1][1] = 8'h80;
        run(1, 8'h02, -1, 1'b0, res, lat, ndone, busy_bad);
        check("n2_reduce_result", res, 8'h1D);

        // N=2: 0xFF*2 = 0xE3, ^0x1C = 0xFF.
        mem[1][0] = 8'h1C; mem[1][1] = 8'hFF;
        run(1, 8'h02, -1, 1'b0, res, lat, ndone, busy_bad);
        check("n2_ff_result", res, 8'hFF);

        // N=3: all ones at r=2 -> ((1*2)^1)*2^1 = 7; reads go 2,1,0.
        mem[2][0] = 8'h01; mem[2][1] = 8'h01; mem[2][2] = 8'h01;
        run(2, 8'h02, -1, 1'b0, res, lat, ndone, busy_bad);
        check("n3_ones_result", res, 8'h07);
        check("n3_ones_latency", lat, 8);
        check("n3_addr_count", addr_q.size(), 3);
        if (addr_q.size() == 3) begin
            check("n3_addr_0", addr_q[0], 2);
            check("n3_addr_1", addr_q[1], 1);
            check("n3_addr_2", addr_q[2], 0);
        end

        // N=3: x^2 at r=3 -> 3*3 = 5.
        mem[2][0] = 8'h00; mem[2][1] = 8'h00; mem[2][2] = 8'h01;
        run(2, 8'h03, -1, 1'b0, res, lat, ndone, busy_bad);
        check("n3_square_result", res, 8'h05);

        // N=8, c_i = i+1: r=1 gives XOR of all, r=0 gives c0.
        for (int a = 0; a < 8; a++) mem[3][a] = 8'(a + 1);
        run(3, 8'h01, -1, 1'b0, res, lat, ndone, busy_bad);
        check("n8_r1_result", res, 8'h08);
        check("n8_r1_latency", lat, 23);
        check("n8_r1_busy", busy_bad, 0);
        run(3, 8'h00, -1, 1'b0, res, lat, ndone, busy_bad);
        check("n8_r0_result", res, 8'h01);
        check("n8_r0_latency", lat, 23);

        // Starts while busy and in the DONE cycle are both dropped.
        run(3, 8'h01, 5, 1'b1, res, lat, ndone, busy_bad);
        check("ign_result", res, 8'h08);
        check("ign_latency", lat, 23);
        check("ign_ndone", ndone, 1);
        check("ign_idle_busy", busy_v[3], 0);
        check("ign_result_hold", res_v[3], 8'h08);

        // Asynchronous reset while in WAIT.
        @(posedge clk);
        #1;
        eval_point = 8'h01;
        start_v[3] = 1'b1;
        @(posedge clk);
        #1;
        start_v[3] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pre_busy", busy_v[3], 1);
        rst_n = 1'b0;
        #1;
        check("rst_busy", busy_v[3], 0);
        check("rst_done", done_v[3], 0);
        check("rst_result", res_v[3], 0);
        check("rst_rd", rd_v[3], 0);
        check("rst_addr", addr_v[3], 0);
        #3;
        rst_n = 1'b1;
        run(3, 8'h00, -1, 1'b0, res, lat, ndone, busy_bad);
        check("post_rst_result", res, 8'h01);
        check("post_rst_ndone", ndone, 1);
        check("post_rst_latency", lat, 23);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
